// File: rtl/demux_pkg.sv
// demux_pkg: shared defaults and elaboration-time parameter checks for demux_router
// Contents: default DATA_W/CHANNELS/SEL_W/CNT_W, clog2, select-width legality check.
package demux_pkg;

    localparam int DEF_DATA_W   = 4;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_SEL_W    = 2;
    localparam int DEF_CNT_W    = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // True when a select of sel_w bits can address every one of the channels.
    function automatic bit sel_w_ok(input int sel_w, input int channels);
        return sel_w >= clog2(channels);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry channel buffer with valid/ready drain and pass-through refill
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   load, load_data       write request and payload from the router
//   out_ready             consumer ready for this channel
//   full                  entry held (drives out_valid for the channel)
//   free                  entry can accept a load this cycle (empty or draining)
//   data                  held payload; keeps its last value after a drain
module demux_slot import demux_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              full,
    output logic              free,
    output logic [DATA_W-1:0] data
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        full_d = load || (full_q && !out_ready);
        data_d = load ? load_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign free = !full_q || out_ready;
    assign data = data_q;

endmodule

// File: rtl/demux_router.sv
// demux_router: registered 1-to-N demultiplexer with valid/ready handshakes and drop counter
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     producer handshake; in_ready is low while in reset
//   in_sel, in_data       destination channel and payload
//   in_bcast              broadcast to all channels (only with DEMUX_ROUTER_BCAST_EN defined)
//   out_valid/out_ready   per-channel consumer handshake
//   out_data              channel k at [k*DATA_W +: DATA_W]
//   drop_cnt              saturating count of out-of-range transactions
// Optional feature macro: DEMUX_ROUTER_BCAST_EN
module demux_router import demux_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = DEF_SEL_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SEL_W-1:0]           in_sel,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_bcast,
    output logic [CHANNELS-1:0]        out_valid,
    input  logic [CHANNELS-1:0]        out_ready,
    output logic [CHANNELS*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int             NSEL = 1 << SEL_W;
    localparam logic [SEL_W:0] CH_L = (SEL_W + 1)'(CHANNELS);

    if (!sel_w_ok(SEL_W, CHANNELS) || CHANNELS < 2 || CHANNELS > 16) begin : g_bad_params
        $error("demux_router: CHANNELS must be 2..16 and 2**SEL_W >= CHANNELS");
    end

    logic [CHANNELS-1:0] free, load;
    logic [NSEL-1:0]     free_pad;
    logic                in_range, bcast, accept;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

`ifdef DEMUX_ROUTER_BCAST_EN
    assign bcast = in_bcast;
`else
    logic unused_bcast;
    assign unused_bcast = in_bcast;
    assign bcast        = 1'b0;
`endif

    assign in_range = {1'b0, in_sel} < CH_L;
    // Zero-padded so any select value indexes safely; out-of-range lanes are never used.
    assign free_pad = NSEL'(free);

    always_comb begin
        in_ready   = !rst_n ? 1'b0 : bcast ? &free : in_range ? free_pad[in_sel] : 1'b1;
        accept     = in_valid && in_ready;
        drop_cnt_d = (accept && !bcast && !in_range && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
        assign load[k] = accept && (bcast || (in_range && in_sel == SEL_W'(k)));
        demux_slot #(.DATA_W(DATA_W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .full      (out_valid[k]),
            .free      (free[k]),
            .data      (out_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: scoreboard bench for demux_router with directed and random traffic
module tb_demux_router;

    localparam int CH   = 3;
    localparam int DW   = 4;
    localparam int SW   = 2;
    localparam int CW   = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [SW-1:0]     in_sel = '0;
    logic [DW-1:0]     in_data = '0;
    logic              in_bcast = 1'b0;
    logic [CH-1:0]     out_valid;
    logic [CH-1:0]     out_ready = '1;
    logic [CH*DW-1:0]  out_data;
    logic [CW-1:0]     drop_cnt;

    demux_router #(.DATA_W(DW), .CHANNELS(CH), .SEL_W(SW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_bcast  (in_bcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each channel is a queue of at most one payload,
    // last[] is the payload the channel last presented (0 after reset).
    logic [DW-1:0] q[CH][$];
    logic [DW-1:0] last[CH];
    int            drops = 0;

    logic          pend_valid = 1'b0;
    logic          pend_bc = 1'b0;
    int            pend_sel = 0;
    logic [DW-1:0] pend_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit bcast_on();
`ifdef DEMUX_ROUTER_BCAST_EN
        return in_bcast;
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: compares DUT outputs against the model and pops on every transfer.
    always @(negedge clk) begin
        logic          e;
        logic [CH-1:0] ev;
        logic [DW-1:0] d;
        bit            all_free;
        all_free = 1'b1;
        for (int k = 0; k < CH; k++) begin
            ev[k] = q[k].size() != 0;
            if (ev[k] && !out_ready[k]) all_free = 1'b0;
        end
        chk("out_valid", 32'(out_valid), 32'(ev));
        for (int k = 0; k < CH; k++)
            chk($sformatf("out_data%0d", k), 32'(out_data[k*DW +: DW]), 32'(last[k]));
        chk("drop_cnt", 32'(drop_cnt), 32'(drops > MAXC ? MAXC : drops));
        if (!rst_n)                e = 1'b0;
        else if (bcast_on())       e = all_free;
        else if (int'(in_sel) < CH) e = !ev[in_sel] || out_ready[in_sel];
        else                       e = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(e));
        pend_valid = rst_n && in_valid && e;
        pend_bc    = bcast_on();
        pend_sel   = int'(in_sel);
        pend_data  = in_data;
        if (rst_n)
            for (int k = 0; k < CH; k++)
                if (ev[k] && out_ready[k]) begin
                    d = q[k].pop_front();
                    chk($sformatf("pop%0d", k), 32'(out_data[k*DW +: DW]), 32'(d));
                end
    end

    // One clock of stimulus: commit last cycle's accepted transaction to the model, then drive.
    task automatic step(input logic rn, input logic v, input int s, input logic [DW-1:0] d,
                        input logic [CH-1:0] r, input logic b);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            for (int k = 0; k < CH; k++) begin
                q[k].delete();
                last[k] = '0;
            end
            drops = 0;
        end else if (pend_valid) begin
            if (pend_bc) begin
                for (int k = 0; k < CH; k++) begin
                    q[k].push_back(pend_data);
                    last[k] = pend_data;
                end
            end else if (pend_sel < CH) begin
                q[pend_sel].push_back(pend_data);
                last[pend_sel] = pend_data;
            end else begin
                drops++;
            end
        end
        rst_n     = rn;
        in_valid  = v;
        in_sel    = SW'(s);
        in_data   = d;
        out_ready = r;
        in_bcast  = b;
    endtask

    initial begin
        for (int k = 0; k < CH; k++) last[k] = '0;
        step(0, 0, 0, 4'h0, 3'b111, 0);
        step(0, 0, 0, 4'h0, 3'b111, 0);
        // Single transfer to channel 0.
        step(1, 1, 0, 4'hA, 3'b111, 0);
        step(1, 0, 0, 4'h0, 3'b111, 0);
        step(1, 0, 0, 4'h0, 3'b111, 0);
        // Backpressure on ch2; ch1 keeps flowing; held retry then pass-through.
        step(1, 1, 2, 4'h5, 3'b011, 0);
        step(1, 1, 2, 4'h6, 3'b011, 0);
        step(1, 1, 1, 4'h7, 3'b011, 0);
        step(1, 1, 2, 4'h6, 3'b011, 0);
        step(1, 1, 2, 4'h6, 3'b111, 0);
        step(1, 0, 0, 4'h0, 3'b011, 0);
        step(1, 0, 0, 4'h0, 3'b111, 0);
        // Pass-through refill on ch0.
        step(1, 1, 0, 4'h3, 3'b111, 0);
        step(1, 1, 0, 4'h9, 3'b111, 0);
        step(1, 0, 0, 4'h0, 3'b000, 0);
        step(1, 0, 0, 4'h0, 3'b111, 0);
        // Out-of-range drops, past saturation.
        for (int i = 0; i < MAXC + 2; i++) step(1, 1, 3, 4'(i), 3'b111, 0);
        // Reset in the middle of held data.
        step(1, 1, 0, 4'hE, 3'b000, 0);
        step(1, 1, 2, 4'hD, 3'b000, 0);
        step(0, 1, 1, 4'hB, 3'b000, 0);
        step(1, 1, 1, 4'h2, 3'b111, 0);
        step(1, 0, 0, 4'h0, 3'b111, 0);
        // Random traffic, including occasional reset and broadcast requests.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                 DW'($urandom), CH'($urandom), $urandom_range(0, 7) == 0);
        step(1, 0, 0, 4'h0, 3'b111, 0);
        step(1, 0, 0, 4'h0, 3'b111, 0);
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
